// File: rtl/timer_tick_ctrl.sv
// Round-timer control stage: latches the BCD preset, loads the digit chain and
// issues prescaled decrement pulses, with pause/abort and a runaway guard.
module timer_tick_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_ones,
   input  logic       chain_stop,
   output logic       load,
   output logic [3:0] tens_num,
   output logic [3:0] ones_num,
   output logic       decrement,
   output logic       running,
   output logic       paused,
   output logic       expired,
   output logic       expire_pulse,
   output logic       overrun
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

   function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
      return (digit > 4'd9) ? 4'd9 : digit;
   endfunction

   // Runaway bound: the expected pulse count plus two pulses of slack.
   function automatic logic [7:0] round_limit(input logic [3:0] tens, input logic [3:0] ones);
      return ({4'd0, tens} * 8'd10) + {4'd0, ones} + 8'd2;
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] presc_r;
   logic [CNT_W-1:0] presc_s;
   logic [7:0]       pulses_r;
   logic [7:0]       pulses_s;
   logic [7:0]       limit_r;
   logic             overrun_s;
   logic             dec_s;
   logic             latch_s;

   // Next-state, prescaler and pulse-counter logic with the fixed event priority.
   always_comb begin
      state_s   = state_r;
      presc_s   = presc_r;
      pulses_s  = pulses_r;
      overrun_s = overrun;
      dec_s     = 1'b0;
      latch_s   = 1'b0;
      if (abort) begin
         state_s   = ST_IDLE;
         overrun_s = 1'b0;
      end else if (start) begin
         state_s   = ST_LOAD;
         overrun_s = 1'b0;
         latch_s   = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_LOAD: begin
               presc_s  = '0;
               pulses_s = 8'd0;
               if ((tens_num == 4'd0) && (ones_num == 4'd0)) begin
                  state_s = ST_EXPIRED;
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_RUN: begin
               if (chain_stop) begin
                  state_s = ST_EXPIRED;
               end else if (pulses_r >= limit_r) begin
                  overrun_s = 1'b1;
                  state_s   = ST_EXPIRED;
               end else if (pause) begin
                  state_s = ST_PAUSE;
               end else if (presc_r == PRESC_LAST) begin
                  // Pulse is registered, so it lands TICK_DIV cycles after RUN entry.
                  presc_s  = '0;
                  dec_s    = 1'b1;
                  pulses_s = (pulses_r == 8'hFF) ? pulses_r : (pulses_r + 8'd1);
               end else begin
                  presc_s = presc_r + CNT_W'(1);
               end
            end
            ST_PAUSE: begin
               if (chain_stop) begin
                  state_s = ST_EXPIRED;
               end else if (!pause) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_PAUSE;
               end
            end
            ST_EXPIRED: begin
               state_s = ST_EXPIRED;
            end
            default: begin
               state_s   = ST_IDLE;
               overrun_s = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         presc_r      <= '0;
         pulses_r     <= 8'd0;
         limit_r      <= 8'd0;
         tens_num     <= 4'd0;
         ones_num     <= 4'd0;
         overrun      <= 1'b0;
         load         <= 1'b0;
         decrement    <= 1'b0;
         running      <= 1'b0;
         paused       <= 1'b0;
         expired      <= 1'b0;
         expire_pulse <= 1'b0;
      end else begin
         state_r      <= state_s;
         presc_r      <= presc_s;
         pulses_r     <= pulses_s;
         overrun      <= overrun_s;
         load         <= (state_s == ST_LOAD);
         decrement    <= dec_s;
         running      <= (state_s == ST_RUN);
         paused       <= (state_s == ST_PAUSE);
         expired      <= (state_s == ST_EXPIRED);
         expire_pulse <= (state_s == ST_EXPIRED) && (state_r != ST_EXPIRED);
         if (latch_s) begin
            tens_num <= clamp_bcd(preset_tens);
            ones_num <= clamp_bcd(preset_ones);
            limit_r  <= round_limit(clamp_bcd(preset_tens), clamp_bcd(preset_ones));
         end else begin
            limit_r  <= limit_r;
         end
      end
   end

endmodule

// File: doc/timer_tick_ctrl.md
Name: timer_tick_ctrl

Overview:
- Control stage directly upstream of the cascaded BCD countdown digits in the memory-game timer.
- Latches a two-digit BCD preset and drives the digits' load and input value.
- Generates prescaled one-cycle decrement pulses for the least-significant digit and watches the chain's stop indication to declare time-up.
- Also provides pause/abort control and a runaway guard for the round timer.

Parameters:
TICK_DIV, 50000000, clock cycles per decrement pulse (>=2).
CNT_W, 26, width of prescaler counter (must hold TICK_DIV-1).

Ports:
clock  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request: latch preset and (re)start countdown
pause  input  1  level: hold countdown while high
abort  input  1  one-cycle request: stop and return to idle
preset_tens  input  4  BCD tens preset
preset_ones  input  4  BCD ones preset
chain_stop  input  1  stop indication from the digit chain (all digits reached zero)
load  output  1  load strobe to every digit
tens_num  output  4  preset value to tens digit
ones_num  output  4  preset value to ones digit
decrement  output  1  one-cycle decrement pulse to ones digit
running  output  1  high in RUN
paused  output  1  high in PAUSE
expired  output  1  level, high in EXPIRED
expire_pulse  output  1  one cycle on entry to EXPIRED
overrun  output  1  sticky error: chain failed to stop in time

Behaviour:
- Reset (rst=1 at edge): state IDLE; all outputs 0; tens_num=ones_num=0; prescaler=0; pulse counter=0; overrun=0. Reset overrides everything, including mid-RUN.
- Priority per cycle: rst > abort > start > chain_stop > pause > tick.
- Preset latch on accepted start: each nibble >9 clamps to 9. tens_num/ones_num hold the latched value until the next start or reset.
- Limit: limit = 10*tens + ones + 2 (8-bit), computed at latch.
- States:
  - IDLE: outputs quiet. start -> LOAD.
  - LOAD (1 cycle): load=1. Prescaler and pulse counter cleared. Next state is EXPIRED if latched preset == 00, else RUN.
  - RUN: running=1. Prescaler counts 0..TICK_DIV-1 and wraps.
    - When prescaler == TICK_DIV-1, decrement=1 for that cycle and pulse counter +1 (saturating at 255).
    - chain_stop=1 -> EXPIRED. No decrement that cycle, even if a tick coincides.
    - pause=1 -> PAUSE.
    - Pulse counter reaching limit without chain_stop -> overrun=1, go to EXPIRED.
  - PAUSE: paused=1. Prescaler and pulse counter frozen. pause=0 -> RUN, resuming from the frozen prescaler value. chain_stop in PAUSE -> EXPIRED.
  - EXPIRED: expired=1. expire_pulse=1 only on the first cycle. start -> LOAD (new round); abort -> IDLE.
- abort in any state -> IDLE next cycle. load and decrement are not asserted that cycle. overrun is cleared.
- start in RUN/PAUSE/EXPIRED -> LOAD (restart with a new preset). overrun is cleared on an accepted start.
- start and abort in the same cycle: abort wins.
- decrement is never high in the same cycle as load, and never outside RUN.
- First decrement comes exactly TICK_DIV cycles after the RUN entry edge.
- chain_stop is sampled only in RUN/PAUSE; it is ignored elsewhere.

Test Plan:
- TICK_DIV=4, start with preset 0x1/0x2 (12) -> load high 1 cycle with tens_num=1, ones_num=2; decrement every 4th cycle in RUN, first pulse 4 cycles after RUN entry.
- Preset 0/3, chain_stop asserted after the 3rd decrement, coinciding with a tick -> no 4th decrement; expire_pulse for 1 cycle; expired stays high; running=0.
- pause high for 10 cycles with the prescaler at 2 -> no decrement during pause; the next decrement comes 2 cycles after pause drops.
- Preset 0xC/0xF -> clamped to 9/9; preset 00 -> LOAD then immediate EXPIRED with zero decrements.
- Preset 0/2 with chain_stop tied 0 -> exactly 4 decrements, then overrun=1 and expired=1; a following start clears overrun and reloads.
- rst mid-RUN and abort+start in the same cycle -> IDLE with all outputs 0 next cycle; no load pulse.
